// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. It issues one read on memory port 1, then latches
// the returned word together with its address and offers it to decode. It
// runs as a three-state loop: request, response, hold. Memory port 1 is a
// synchronous read, so mem_ir carries the data for the address presented on
// the previous cycle.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   redirect     branch/jump taken: restart fetching at redirect_pc
//   redirect_pc  target address for redirect
//   stall        hazard hold from control; blocks only the hold handshake
//   inst_ready   decode accepts inst this cycle
//   mem_ir       port-1 read data, valid the cycle after a1/r1
//   a1           port-1 address (always the current pc)
//   r1           port-1 read strobe, high in the request state
//   w1           port-1 write strobe, tied low
//   inst         latched instruction word
//   inst_pc      address inst was fetched from
//   inst_valid   inst/inst_pc hold an instruction waiting for decode
//   fetch_count  number of instructions accepted by decode (16-bit wrap)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  input  logic        inst_ready,
  input  logic [15:0] mem_ir,
  output logic [15:0] a1,
  output logic        r1,
  output logic        w1,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic        inst_valid,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ,
    S_RESP,
    S_HOLD
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic        r1_q;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the values from before the edge, independent of order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      inst        <= 16'h0000;
      inst_pc     <= 16'h0000;
      inst_valid  <= 1'b0;
      fetch_count <= 16'h0000;
      r1_q        <= 1'b1;
    end else if (redirect) begin
      // Redirect wins in every state. In S_RESP the word arriving on mem_ir
      // belongs to the abandoned path, so inst/inst_pc are left untouched.
      state      <= S_REQ;
      pc         <= redirect_pc;
      inst_valid <= 1'b0;
      r1_q       <= 1'b1;
    end else begin
      case (state)
        S_REQ: begin
          state <= S_RESP;
          r1_q  <= 1'b0;
        end
        S_RESP: begin
          inst       <= mem_ir;
          inst_pc    <= pc;
          pc         <= pc + PC_STEP;
          inst_valid <= 1'b1;
          state      <= S_HOLD;
        end
        S_HOLD: begin
          if (inst_ready && !stall) begin
            fetch_count <= fetch_count + 16'h0001;
            inst_valid  <= 1'b0;
            state       <= S_REQ;
            r1_q        <= 1'b1;
          end
        end
        default: begin
          state      <= S_REQ;
          inst_valid <= 1'b0;
          r1_q       <= 1'b1;
        end
      endcase
    end
  end

  // The read strobe is kept as its own register (high exactly in S_REQ) so
  // the memory sees a glitch-free strobe straight from a flop.
  assign a1 = pc;
  assign r1 = r1_q;
  assign w1 = 1'b0;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. A synchronous-read memory feeds
// mem_ir. A reference model tracks the fetch as a transaction: the next
// fetch address, whether a read is outstanding, whether an instruction is
// on offer, and how many were accepted. Directed scenarios come first,
// then a randomized run.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] PC_STEP  = 16'h0001;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        inst_ready;
  logic [15:0] mem_ir;
  logic [15:0] a1;
  logic        r1;
  logic        w1;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic [15:0] fetch_count;

  fetch_stage #(
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .inst_ready (inst_ready),
    .mem_ir     (mem_ir),
    .a1         (a1),
    .r1         (r1),
    .w1         (w1),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory on port 1.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (r1) mem_ir <= mem[a1];
  end

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [15:0] m_pc;
  logic        m_pending;  // a read was issued, data lands on the next edge
  logic        m_valid;    // an instruction is on offer to decode
  logic [15:0] m_inst;
  logic [15:0] m_inst_pc;
  logic [15:0] m_count;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = RESET_PC;
    m_pending = 1'b0;
    m_valid   = 1'b0;
    m_inst    = 16'h0000;
    m_inst_pc = 16'h0000;
    m_count   = 16'h0000;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".a1"},          a1,                     m_pc);
    check({tag, ".r1"},          {15'd0, r1},            {15'd0, !m_valid && !m_pending});
    check({tag, ".w1"},          {15'd0, w1},            16'h0000);
    check({tag, ".inst_valid"},  {15'd0, inst_valid},    {15'd0, m_valid});
    check({tag, ".inst"},        inst,                   m_inst);
    check({tag, ".inst_pc"},     inst_pc,                m_inst_pc);
    check({tag, ".fetch_count"}, fetch_count,            m_count);
  endtask

  // One clock: drive inputs, advance the model on the edge, check at negedge.
  task automatic step(input string tag, input logic rd, input logic [15:0] rpc,
                      input logic st, input logic rdy);
    redirect    = rd;
    redirect_pc = rpc;
    stall       = st;
    inst_ready  = rdy;
    @(posedge clk);
    if (rd) begin
      m_pc      = rpc;
      m_valid   = 1'b0;
      m_pending = 1'b0;
    end else if (m_pending) begin
      m_inst    = mem[m_pc];
      m_inst_pc = m_pc;
      m_pc      = m_pc + PC_STEP;
      m_valid   = 1'b1;
      m_pending = 1'b0;
    end else if (m_valid) begin
      if (rdy && !st) begin
        m_count = m_count + 16'h0001;
        m_valid = 1'b0;
      end
    end else begin
      m_pending = 1'b1;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0]      = 16'h1234;
    mem[1]      = 16'hABCD;
    mem[16'hFFFF] = 16'h5A5A;

    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    stall       = 1'b0;
    inst_ready  = 1'b0;
    model_reset();
    #1;
    check_all("reset");

    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("reset_release");

    // Basic fetch of 16'h1234 from address 0, accepted on the third edge.
    step("basic_req",    1'b0, 16'h0000, 1'b0, 1'b1);
    step("basic_resp",   1'b0, 16'h0000, 1'b0, 1'b1);
    check("basic_inst", inst, 16'h1234);
    step("basic_accept", 1'b0, 16'h0000, 1'b0, 1'b1);
    check("basic_count", fetch_count, 16'h0001);

    // Stall hold with inst=16'hABCD, then release.
    step("stall_req",  1'b0, 16'h0000, 1'b1, 1'b1);
    step("stall_resp", 1'b0, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step("stall_hold", 1'b0, 16'h0000, 1'b1, 1'b1);
    check("stall_inst", inst, 16'hABCD);
    step("stall_release", 1'b0, 16'h0000, 1'b0, 1'b1);
    check("stall_count", fetch_count, 16'h0002);

    // Redirect while in S_RESP discards the in-flight word.
    step("rresp_req", 1'b0, 16'h0000, 1'b0, 1'b1);
    step("rresp_redirect", 1'b1, 16'h0040, 1'b0, 1'b1);
    check("rresp_inst_kept", inst, 16'hABCD);
    check("rresp_a1", a1, 16'h0040);

    // Redirect together with accept in S_HOLD: no count.
    step("racc_req",  1'b0, 16'h0000, 1'b0, 1'b0);
    step("racc_resp", 1'b0, 16'h0000, 1'b0, 1'b0);
    step("racc_redirect", 1'b1, 16'h0080, 1'b0, 1'b1);
    check("racc_count", fetch_count, 16'h0002);

    // Wrap: fetch from 16'hFFFF, next address 16'h0000.
    step("wrap_redirect", 1'b1, 16'hFFFF, 1'b0, 1'b1);
    step("wrap_req",  1'b0, 16'h0000, 1'b0, 1'b1);
    step("wrap_resp", 1'b0, 16'h0000, 1'b0, 1'b1);
    check("wrap_inst_pc", inst_pc, 16'hFFFF);
    step("wrap_accept", 1'b0, 16'h0000, 1'b0, 1'b1);
    check("wrap_a1", a1, 16'h0000);

    // Asynchronous reset between edges during S_RESP.
    step("areset_req", 1'b0, 16'h0000, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("areset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("areset_release");

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 15) == 0),
           16'($urandom),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, the first fetch address after reset.
REQ-002 The block SHALL have parameter PC_STEP, default 16'h0001, the PC increment per instruction (word addressing).
REQ-003 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high, with ports named as the codebase does:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- redirect  input  1  branch/jump taken; load redirect_pc
- redirect_pc  input  16  target address for redirect
- stall  input  1  hazard hold from control; blocks the handshake
- inst_ready  input  1  decode stage accepts inst this cycle
- mem_ir  input  16  instruction word from the memory port-1 read data (IR)
- a1  output  16  memory port-1 address
- r1  output  1  memory port-1 read strobe
- w1  output  1  memory port-1 write strobe, constant 0
- inst  output  16  latched instruction
- inst_pc  output  16  address inst was fetched from
- inst_valid  output  1  inst/inst_pc hold a valid instruction
- fetch_count  output  16  number of instructions accepted by decode

Function
REQ-004 Memory port 1 SHALL be treated as synchronous read: mem_ir is valid the cycle after a1/r1 are presented.
REQ-005 The FSM SHALL have three states: S_REQ, S_RESP and S_HOLD.
REQ-006 In S_REQ: a1=pc, r1=1, inst_valid=0; next state SHALL be S_RESP.
REQ-007 In S_RESP: r1=0; on the clock edge inst<=mem_ir, inst_pc<=pc, pc<=pc+PC_STEP, inst_valid<=1; next state SHALL be S_HOLD.
REQ-008 In S_HOLD: inst_valid=1, r1=0; if inst_ready=1 and stall=0, then fetch_count<=fetch_count+1, inst_valid<=0 and next state SHALL be S_REQ; otherwise the block SHALL stay in S_HOLD with inst and inst_pc unchanged.
REQ-009 a1 SHALL equal pc in every state; w1 SHALL be 0 at all times.
REQ-010 Steady-state throughput SHALL be one instruction per 3 cycles when inst_ready=1 and stall=0.
REQ-011 The redirect=1 event SHALL have priority over every other event in any state:
- pc<=redirect_pc
- inst_valid<=0
- next state S_REQ
- no fetch_count increment, even if inst_ready=1 in S_HOLD
REQ-012 A redirect in S_RESP SHALL discard the in-flight mem_ir; inst and inst_pc SHALL retain their previous values.
REQ-013 pc and fetch_count SHALL be 16-bit modulo: 16'hFFFF+PC_STEP wraps without error or flag.
REQ-014 stall SHALL affect only the S_HOLD handshake; S_REQ and S_RESP SHALL proceed regardless of stall.
REQ-015 The accept condition inst_ready=1 outside S_HOLD SHALL be ignored.

Reset
REQ-016 On reset=1, regardless of clk, the block SHALL immediately force:
- state=S_REQ
- pc=RESET_PC
- inst=16'h0000, inst_pc=16'h0000
- inst_valid=0
- fetch_count=16'h0000
REQ-017 Reset asserted mid-fetch SHALL abandon the fetch; outputs SHALL follow REQ-016 within the same cycle.
REQ-018 After reset deasserts, the first clock edge SHALL see S_REQ with a1=RESET_PC and r1=1.

Verification
REQ-019 Basic fetch: memory holds 16'h1234 at addr 0; release reset with inst_ready=1 -> r1 pulses with a1=0, two edges later inst=16'h1234, inst_pc=0, inst_valid=1; next edge fetch_count=1 and a1=1.
REQ-020 Stall hold: in S_HOLD with inst=16'hABCD, stall=1 and inst_ready=1 for 5 cycles -> inst_valid stays 1, inst stays 16'hABCD, fetch_count unchanged; deassert stall -> accepted on the next edge.
REQ-021 Redirect in S_RESP: redirect=1 with redirect_pc=16'h0040 while S_RESP -> inst_valid stays 0, inst keeps its old value, next a1=16'h0040 with r1=1.
REQ-022 Redirect vs accept: in S_HOLD, redirect=1 together with inst_ready=1 -> fetch_count not incremented, next a1=redirect_pc.
REQ-023 Wrap: redirect to 16'hFFFF, fetch completes -> inst_pc=16'hFFFF, following a1=16'h0000.
REQ-024 Async reset: assert reset between clock edges during S_RESP -> inst_valid=0 and a1=RESET_PC before the next clk edge; fetch_count=0.
